// File: rtl/aes_round_engine.sv
// AES-128 iterative encryption core: one round per clock, key schedule read combinationally.
// Build option: define AES_KEY_READY_GATE_EN to accept start only while key_ready is high.

module sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] b;
        p = 8'h00;
        b = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ b;
            b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    always_comb begin
        sq  = a_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
    end

    assign y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_round_engine (
    input  logic          clk,
    input  logic          rst,
    input  logic [1407:0] key_sched,
    input  logic          key_ready,
    input  logic          start,
    input  logic [127:0]  data_in,
    output logic          busy,
    output logic          done,
    output logic [127:0]  data_out
);
    typedef enum logic {IDLE, RUN} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic         done_q, done_d;
    logic [127:0] dout_q, dout_d;

    logic [127:0] rk [11];
    logic [127:0] sub_bytes;
    logic [127:0] shift_rows;
    logic [127:0] mix_cols;
    logic [127:0] round_out;
    logic         start_ok;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar r = 0; r < 11; r++) begin : g_rk
        assign rk[r] = key_sched[1407-128*r -: 128];
    end

    for (genvar b = 0; b < 16; b++) begin : g_sbox
        sbox u_sbox (
            .a_i (state_q[127-8*b -: 8]),
            .y_o (sub_bytes[127-8*b -: 8])
        );
    end

    // Byte index is row + 4*column; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shift_rows[127-8*(r+4*c) -: 8] = sub_bytes[127-8*(r+4*((c+r)%4)) -: 8];
        end

        logic [7:0] a0, a1, a2, a3;
        assign a0 = shift_rows[127-32*c -: 8];
        assign a1 = shift_rows[119-32*c -: 8];
        assign a2 = shift_rows[111-32*c -: 8];
        assign a3 = shift_rows[103-32*c -: 8];

        assign mix_cols[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

    // The final round skips MixColumns.
    assign round_out = ((round_q == 4'd10) ? shift_rows : mix_cols) ^ rk[round_q];

`ifdef AES_KEY_READY_GATE_EN
    assign start_ok = start & key_ready;
`else
    logic unused_key_ready;
    assign unused_key_ready = key_ready;
    assign start_ok         = start;
`endif

    always_comb begin
        // NOTE: every _d gets a default first, so no path can infer a latch.
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        case (fsm_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = data_in ^ rk[0];
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (round_q == 4'd10) begin
                    dout_d  = round_out;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end else begin
                    state_d = round_out;
                    round_d = round_q + 4'd1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign busy     = (fsm_q == RUN);
    assign done     = done_q;
    assign data_out = dout_q;
endmodule
